// File: rtl/shift_rows_pipe_pkg.sv
// Shared constants and elaboration-time helpers for the ShiftRows pipeline:
// legal column counts, per-row rotation offsets and byte bit positions.
package shift_rows_pipe_pkg;

  // Rijndael column counts this block supports.
  localparam int NB_LEGAL [3] = '{4, 6, 8};

  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

  function automatic logic is_legal_nb(input int nb);
    return (nb == NB_LEGAL[0]) || (nb == NB_LEGAL[1]) || (nb == NB_LEGAL[2]);
  endfunction

  // Left-rotation amount of row r. Wide (Nb=8) states spread rows 2 and 3 further.
  function automatic int shift_of(input int nb, input int r);
    case (r)
      0:       return 0;
      1:       return 1;
      2:       return (nb == 8) ? 3 : 2;
      default: return (nb == 8) ? 4 : 3;
    endcase
  endfunction

  // Byte 0 sits in the most significant byte lane of the state word.
  function automatic int byte_msb(input int nb, input int k);
    return 32 * nb - 1 - 8 * k;
  endfunction

endpackage

// File: rtl/shift_rows_pipe_if.sv
// Valid/ready stream carrying a column-major state plus mode and tag in,
// permuted state plus tag out, and a pipeline occupancy flag.
interface shift_rows_pipe_if #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [32*NB-1:0]    in_data;
  logic                in_inv;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [32*NB-1:0]    shift_data;
  logic [TAG_W-1:0]    out_tag;
  logic                busy;

  modport master (
    output in_valid, in_data, in_inv, in_tag, out_ready,
    input  in_ready, out_valid, shift_data, out_tag, busy
  );

  modport slave (
    input  in_valid, in_data, in_inv, in_tag, out_ready,
    output in_ready, out_valid, shift_data, out_tag, busy
  );
endinterface

// File: rtl/shift_rows_perm.sv
// Combinational (Inv)ShiftRows byte permutation. Every output byte is a
// fixed two-way choice between the forward and inverse source byte.
module shift_rows_perm
  import shift_rows_pipe_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] data,
  input  logic             inv,
  output logic [32*NB-1:0] perm
);

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SH      = shift_of(NB, r);
      localparam int SRC_FWD = (c + SH) % NB;
      localparam int SRC_INV = (c + NB - SH) % NB;
      localparam int DST     = byte_msb(NB, 4 * c + r);
      localparam int FWD_MSB = byte_msb(NB, 4 * SRC_FWD + r);
      localparam int INV_MSB = byte_msb(NB, 4 * SRC_INV + r);

      assign perm[DST -: 8] = inv ? data[INV_MSB -: 8] : data[FWD_MSB -: 8];
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// ShiftRows / InvShiftRows with an elastic STAGES-deep register pipeline.
// The permutation happens before stage 0; later stages only delay the beat.
// Each stage advances when it or any stage below it is empty, or the sink is
// ready, so a full pipeline can drain and accept in the same cycle.
module shift_rows_pipe
  import shift_rows_pipe_pkg::*;
#(
  parameter int NB     = 4,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input logic              clk,
  input logic              rst,
  shift_rows_pipe_if.slave bus
);

  if (!is_legal_nb(NB)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("shift_rows_pipe: STAGES must be 1..4");
  end

  localparam int W = 32 * NB;

  logic [W-1:0]      perm_d;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] adv;
  logic [W-1:0]      data_q [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];

  shift_rows_perm #(.NB(NB)) u_perm (
    .data (bus.in_data),
    .inv  (bus.in_inv),
    .perm (perm_d)
  );

  // Stage i can move iff the sink takes a beat or some stage at or after i
  // has a hole; written flat to keep the ready chain free of feedback.
  for (genvar i = 0; i < STAGES; i++) begin : g_adv
    assign adv[i] = bus.out_ready || !(&valid_q[STAGES-1:i]);
  end

  // Stage registers: load valid, data and tag together only on advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      if (adv[0]) begin
        valid_q[0] <= bus.in_valid;
        data_q[0]  <= perm_d;
        tag_q[0]   <= bus.in_tag;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (adv[i]) begin
          valid_q[i] <= valid_q[i-1];
          data_q[i]  <= data_q[i-1];
          tag_q[i]   <= tag_q[i-1];
        end
      end
    end
  end

  assign bus.in_ready   = adv[0];
  assign bus.out_valid  = valid_q[STAGES-1];
  assign bus.shift_data = data_q[STAGES-1];
  assign bus.out_tag    = tag_q[STAGES-1];
  assign bus.busy       = |valid_q;

endmodule

// File: doc/shift_rows_pipe.md
SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

Interface
REQ-001 Parameter NB, default 4, state columns (Rijndael Nb); legal values 4, 6, 8.
REQ-002 Parameter STAGES, default 1, pipeline register stages; legal range 1..4.
REQ-003 Parameter TAG_W, default 4, width of the passthrough tag.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 IN_VALID  input  1  input beat valid.
REQ-007 IN_READY  output  1  block accepts a beat this cycle.
REQ-008 IN_DATA  input  32*NB  state, column-major.
REQ-009 IN_INV  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled per beat.
REQ-010 IN_TAG  input  TAG_W  opaque sideband, returned unchanged.
REQ-011 OUT_VALID  output  1  output beat valid.
REQ-012 OUT_READY  input  1  downstream accepts the output beat.
REQ-013 SHIFT_DATA  output  32*NB  permuted state.
REQ-014 OUT_TAG  output  TAG_W  tag of the current output beat.
REQ-015 BUSY  output  1  any pipeline stage holds a valid beat.

Function
REQ-016 Byte k SHALL occupy bits [32*NB-1-8k -: 8], with row r = k mod 4 and column c = k div 4.
REQ-017 Row shift offsets SHALL be 0,1,2,3 for NB=4 or 6, and 0,1,3,4 for NB=8.
REQ-018 With IN_INV=0: out(r,c) = in(r,(c+shift(r)) mod NB).
REQ-019 With IN_INV=1: out(r,c) = in(r,(c-shift(r)) mod NB).
REQ-020 The permutation SHALL be applied combinationally before stage 0; stages 1..STAGES-1 only delay data, tag and valid.
REQ-021 A transfer occurs when VALID and READY are both high at a clock edge; latency from input transfer to OUT_VALID SHALL be exactly STAGES cycles with OUT_READY held high.
REQ-022 Throughput SHALL be one beat per cycle with OUT_READY high; no bubbles inserted.
REQ-023 Stage i SHALL advance when it is empty or stage i+1 advances; the last stage advances when it is empty or OUT_READY is high.
REQ-024 IN_READY = stage-0 empty OR stage 0 advances (combinational from OUT_READY through the pipeline).
REQ-025 While OUT_VALID=1 and OUT_READY=0, SHIFT_DATA and OUT_TAG SHALL hold stable and no beat SHALL be lost or duplicated.
REQ-026 Simultaneous output drain and input accept on a full pipeline SHALL succeed in the same cycle.
REQ-027 Beats SHALL leave in acceptance order; mode and tag SHALL travel with their own beat, and mixed modes back-to-back SHALL be legal.
REQ-028 Data registers SHALL load only on advance; contents of empty stages are don't-care but never drive OUT_VALID.

Reset
REQ-029 RST high SHALL immediately clear all stage valid bits: OUT_VALID=0, BUSY=0, IN_READY=1 after release.
REQ-030 SHIFT_DATA and OUT_TAG SHALL reset to zero.
REQ-031 Reset mid-operation SHALL discard all in-flight beats; the first post-reset beat SHALL behave as on a fresh pipeline.

Structure
REQ-032 A shared package SHALL hold the legal NB set, the shift-offset function shift(NB,r), and the byte-index helper.
REQ-033 One sub-module, shift_rows_perm (combinational, parameter NB, inputs data and inv), SHALL implement REQ-016..019; the pipeline/handshake shall live in shift_rows_pipe.
REQ-034 Illegal NB or STAGES SHALL fail elaboration.

Verification
REQ-035 NB=4, IN_INV=0, IN_DATA bytes 00..0F -> SHIFT_DATA bytes 00 05 0A 0F 04 09 0E 03 08 0D 02 07 0C 01 06 0B.
REQ-036 NB=4, IN_INV=1, bytes 00..0F -> 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03; FIPS-197 round-1 d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 with INV=0 -> d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5.
REQ-037 STAGES=3, 10 back-to-back beats with tags 0..9 and alternating INV, OUT_READY=1 -> first OUT_VALID exactly 3 cycles after first accept, 10 consecutive outputs, tags 0..9 in order.
REQ-038 OUT_READY random 50%, 200 beats -> output stable while stalled, every beat matches the reference model exactly once, IN_READY=0 only when all stages are full and OUT_READY=0.
REQ-039 NB=8: bytes 00..1F each mode -> matches model with offsets 0,1,3,4; INV(fwd(x)) == x.
REQ-040 RST asserted with 3 beats in flight -> OUT_VALID and BUSY drop the same cycle, none of the 3 beats ever emerges, and the next beat has latency STAGES.
